fetch_unit: RTL and testbench

Instruction-fetch stage front end for the 8-bit pipeline. It owns the program counter, addresses the combinational instruction memory, and presents `{pc, instr}` to the IF/ID pipeline register's write side. It handles the boot-vector load, stall and redirect control, and interrupt-vector entry. When it has no valid fetch, it emits a NOP (8'h00) so IF/ID captures a bubble.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives imem, handles boot/redirect/interrupt entry.
// Zero-latency pc->imem->instr path; pc_write_en=0 holds PC and outputs, a redirect overrides the hold.
module fetch_unit #(
   parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
   parameter logic [7:0] INT_VEC_ADDR   = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pc_write_en,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_pc,
   input  logic       int_req,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_data,
   output logic [7:0] pc_out,
   output logic [7:0] instr_out,
   output logic       if_valid,
   output logic       int_ack,
   output logic [7:0] int_ret_pc
);

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_INT_VEC = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic       int_pending_q, int_pending_d;
   logic [7:0] int_ret_pc_q, int_ret_pc_d;
   logic       int_ack_q, int_ack_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_BOOT;
         pc_q          <= 8'h00;
         int_pending_q <= 1'b0;
         int_ret_pc_q  <= 8'h00;
         int_ack_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         int_pending_q <= int_pending_d;
         int_ret_pc_q  <= int_ret_pc_d;
         int_ack_q     <= int_ack_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      int_pending_d = int_pending_q;
      int_ret_pc_d  = int_ret_pc_q;
      int_ack_d     = 1'b0;
      imem_addr     = pc_q;
      pc_out        = pc_q;
      instr_out     = 8'h00;
      if_valid      = 1'b0;

      case (state_q)
         ST_BOOT: begin
            imem_addr = RESET_VEC_ADDR;
            pc_d      = imem_data;
            state_d   = ST_RUN;
         end

         ST_RUN: begin
            instr_out     = imem_data;
            if_valid      = 1'b1;
            int_pending_d = int_pending_q | int_req;
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end else if (int_pending_q && pc_write_en) begin
               // Current fetch is dropped; handler returns to this PC.
               int_ret_pc_d  = pc_q;
               int_ack_d     = 1'b1;
               int_pending_d = 1'b0;
               state_d       = ST_INT_VEC;
            end else if (pc_write_en) begin
               pc_d = pc_q + 8'd1;
            end
         end

         ST_INT_VEC: begin
            imem_addr     = INT_VEC_ADDR;
            pc_d          = imem_data;
            state_d       = ST_RUN;
            int_pending_d = int_pending_q | int_req;
            // An older branch resolving now moves the handler's return point.
            if (redirect_valid) begin
               int_ret_pc_d = redirect_pc;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign int_ack    = int_ack_q;
   assign int_ret_pc = int_ret_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test-plan steps followed by random traffic, checked against a behavioural fetch model.
module tb_fetch_unit;

   localparam logic [7:0] RV = 8'h00;
   localparam logic [7:0] IV = 8'h01;
   localparam int M_BOOT = 0;
   localparam int M_RUN  = 1;
   localparam int M_VEC  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       pc_write_en;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic       int_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic [7:0] pc_out;
   logic [7:0] instr_out;
   logic       if_valid;
   logic       int_ack;
   logic [7:0] int_ret_pc;

   logic [7:0] mem [256];

   always #5 clk = ~clk;
   assign imem_data = mem[imem_addr];

   fetch_unit #(.RESET_VEC_ADDR(RV), .INT_VEC_ADDR(IV)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_write_en    (pc_write_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .int_req        (int_req),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .pc_out         (pc_out),
      .instr_out      (instr_out),
      .if_valid       (if_valid),
      .int_ack        (int_ack),
      .int_ret_pc     (int_ret_pc)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int         m_mode;
   logic [7:0] m_pc;
   logic       m_pend;
   logic [7:0] m_ret;
   logic       m_ack;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_BOOT;
      m_pc   = 8'h00;
      m_pend = 1'b0;
      m_ret  = 8'h00;
      m_ack  = 1'b0;
   endtask

   // Applies one rising edge's worth of the fetch rules to the model.
   task automatic model_edge();
      logic take;
      if (!rst) begin
         model_reset();
      end else if (m_mode == M_BOOT) begin
         m_pc   = mem[RV];
         m_mode = M_RUN;
         m_ack  = 1'b0;
      end else if (m_mode == M_VEC) begin
         m_pc   = mem[IV];
         m_mode = M_RUN;
         m_ack  = 1'b0;
         m_pend = m_pend | int_req;
         if (redirect_valid) m_ret = redirect_pc;
      end else begin
         take  = !redirect_valid && m_pend && pc_write_en;
         m_ack = take;
         if (redirect_valid) m_pc = redirect_pc;
         else if (take) begin
            m_ret  = m_pc;
            m_mode = M_VEC;
         end else if (pc_write_en) m_pc = 8'((int'(m_pc) + 1) % 256);
         m_pend = take ? 1'b0 : (m_pend | int_req);
      end
   endtask

   task automatic check_model();
      logic [7:0] e_addr;
      logic [7:0] e_instr;
      logic       e_vld;
      e_addr  = (m_mode == M_BOOT) ? RV : (m_mode == M_VEC) ? IV : m_pc;
      e_vld   = (m_mode == M_RUN);
      e_instr = e_vld ? mem[m_pc] : 8'h00;
      check("imem_addr", imem_addr, e_addr);
      check("pc_out", pc_out, m_pc);
      check("instr_out", instr_out, e_instr);
      check("if_valid", {7'd0, if_valid}, {7'd0, e_vld});
      check("int_ack", {7'd0, int_ack}, {7'd0, m_ack});
      check("int_ret_pc", int_ret_pc, m_ret);
   endtask

   task automatic do_cycle();
      #1;
      check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic we, input logic rv, input logic [7:0] rpc, input logic ir);
      pc_write_en    = we;
      redirect_valid = rv;
      redirect_pc    = rpc;
      int_req        = ir;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
      mem[8'h00] = 8'h20;
      mem[8'h20] = 8'hA5;
      mem[8'h01] = 8'h80;

      rst = 1'b0;
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      @(posedge clk);
      model_reset();
      #1;
      check("rst_addr", imem_addr, 8'h00);
      check("rst_vld", {7'd0, if_valid}, 8'h00);
      check("rst_ack", {7'd0, int_ack}, 8'h00);
      check("rst_ret", int_ret_pc, 8'h00);
      do_cycle();

      // Boot
      rst = 1'b1;
      #1;
      check("boot_addr", imem_addr, 8'h00);
      check("boot_instr", instr_out, 8'h00);
      do_cycle();
      check("boot_pc", pc_out, 8'h20);
      check("boot_instr1", instr_out, 8'hA5);
      check("boot_vld1", {7'd0, if_valid}, 8'h01);

      // Stall and wrap
      drive(1'b1, 1'b1, 8'hFE, 1'b0);
      do_cycle();
      check("wrap_fe0", pc_out, 8'hFE);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      do_cycle();
      check("wrap_fe1", pc_out, 8'hFE);
      do_cycle();
      check("wrap_fe2", pc_out, 8'hFE);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      do_cycle();
      check("wrap_ff", pc_out, 8'hFF);
      do_cycle();
      check("wrap_00", pc_out, 8'h00);

      // Redirect over stall
      drive(1'b1, 1'b1, 8'h10, 1'b0);
      do_cycle();
      drive(1'b0, 1'b1, 8'h40, 1'b0);
      do_cycle();
      check("redir_pc", pc_out, 8'h40);
      check("redir_vld", {7'd0, if_valid}, 8'h01);

      // Interrupt at PC=33 during a one-cycle stall
      drive(1'b1, 1'b1, 8'h33, 1'b0);
      do_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      do_cycle();
      check("int_hold", pc_out, 8'h33);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      do_cycle();
      check("int_ack1", {7'd0, int_ack}, 8'h01);
      check("int_vld0", {7'd0, if_valid}, 8'h00);
      check("int_ret", int_ret_pc, 8'h33);
      do_cycle();
      check("int_ack0", {7'd0, int_ack}, 8'h00);
      check("int_hpc", pc_out, 8'h80);
      check("int_hvld", {7'd0, if_valid}, 8'h01);

      // Redirect during INT_VEC
      drive(1'b1, 1'b1, 8'h50, 1'b0);
      do_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      do_cycle();
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      do_cycle();
      check("iv_ret50", int_ret_pc, 8'h50);
      drive(1'b1, 1'b1, 8'h60, 1'b0);
      do_cycle();
      check("iv_ret60", int_ret_pc, 8'h60);
      check("iv_pc", pc_out, 8'h80);
      drive(1'b1, 1'b0, 8'h00, 1'b0);

      // Reset during INT_VEC with a fresh request
      drive(1'b1, 1'b1, 8'h70, 1'b0);
      do_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      do_cycle();
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      do_cycle();
      check("mr_invec", {7'd0, int_ack}, 8'h01);
      rst = 1'b0;
      int_req = 1'b1;
      do_cycle();
      check("mr_ack", {7'd0, int_ack}, 8'h00);
      check("mr_ret", int_ret_pc, 8'h00);
      check("mr_vld", {7'd0, if_valid}, 8'h00);
      check("mr_addr", imem_addr, 8'h00);
      rst = 1'b1;
      int_req = 1'b0;
      do_cycle();
      for (int i = 0; i < 4; i++) begin
         do_cycle();
         check("mr_noint", {7'd0, int_ack}, 8'h00);
         check("mr_run", {7'd0, if_valid}, 8'h01);
      end

      // Random traffic
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 400; i++) begin
         rst            = ($urandom_range(0, 49) != 0);
         pc_write_en    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 4) == 0);
         redirect_pc    = 8'($urandom);
         int_req        = (m_mode != M_BOOT) && ($urandom_range(0, 9) == 0);
         do_cycle();
      end
      #1;
      check_model();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
